// File: rtl/nibble_demux_pkg.sv
// Shared definitions for the nibble demultiplexer: widths, lane ids,
// per-lane state encoding and the nibble insertion helper.
package nibble_demux_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W           = NIBBLE_W * NIBBLES_PER_WORD;
  localparam int CNT_W            = (NIBBLES_PER_WORD > 1) ? $clog2(NIBBLES_PER_WORD) : 1;

  localparam logic LANE_A = 1'b0;
  localparam logic LANE_B = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES_PER_WORD - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } lane_state_e;

  // Returns word with nibble slot idx replaced; other slots untouched.
  function automatic logic [WORD_W-1:0] insert_nibble(
    input logic [WORD_W-1:0]   word,
    input logic [NIBBLE_W-1:0] nibble,
    input logic [CNT_W-1:0]    idx
  );
    logic [WORD_W-1:0] result;
    result = word;
    for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
      if (idx == CNT_W'(i)) begin
        result[i*NIBBLE_W +: NIBBLE_W] = nibble;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/nibble_demux_2o_lane.sv
// One output lane: collects nibbles LSB-first into a word and holds it
// under a valid/ready handshake. Optional flush (NIBBLE_DEMUX_FLUSH_EN)
// discards a partially assembled word.
module nibble_lane_assembler
  import nibble_demux_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                ready,
`ifdef NIBBLE_DEMUX_FLUSH_EN
  input  logic                flush,
`endif
  output logic [WORD_W-1:0]   word,
  output logic                valid
);

  lane_state_e         state_r;
  logic [CNT_W-1:0]    count_r;
  logic [WORD_W-1:0]   word_r;
  logic                valid_r;
  logic                flush_s;

  // Flush request, tied off when the feature is not built in.
  always_comb begin
`ifdef NIBBLE_DEMUX_FLUSH_EN
    flush_s = flush;
`else
    flush_s = 1'b0;
`endif
  end

  // Lane FSM: FILL collects nibbles, FULL holds the word until drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
      count_r <= CNT_ZERO;
      word_r  <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (flush_s) begin
            count_r <= CNT_ZERO;
          end else if (en) begin
            word_r <= insert_nibble(word_r, nibble, count_r);
            if (count_r == CNT_LAST) begin
              count_r <= CNT_ZERO;
              state_r <= FULL;
              valid_r <= 1'b1;
            end else begin
              count_r <= count_r + CNT_ONE;
            end
          end else begin
            count_r <= count_r;
          end
        end
        FULL: begin
          // The word stays in place; the next fill overwrites it slot by slot.
          if (ready) begin
            state_r <= FILL;
            count_r <= CNT_ZERO;
            valid_r <= 1'b0;
          end else begin
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= FILL;
          count_r <= CNT_ZERO;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign word  = word_r;
  assign valid = valid_r;

endmodule

// File: rtl/nibble_demux_2o.sv
// Two-lane nibble demultiplexer: steers in_nibble to lane A (s=0) or
// lane B (s=1); each lane assembles a word. Optional macro
// NIBBLE_DEMUX_FLUSH_EN adds a flush input that clears partial words.
module nibble_demux_2o
  import nibble_demux_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                s,
  input  logic                in_valid,
  input  logic [NIBBLE_W-1:0] in_nibble,
  output logic                in_ready,
`ifdef NIBBLE_DEMUX_FLUSH_EN
  input  logic                flush,
`endif
  output logic [WORD_W-1:0]   a_word,
  output logic                a_valid,
  input  logic                a_ready,
  output logic [WORD_W-1:0]   b_word,
  output logic                b_valid,
  input  logic                b_ready
);

  logic en_a;
  logic en_b;

  // Ready reflects only the selected lane so a full lane never blocks the other.
  always_comb begin
    case (s)
      LANE_A:  in_ready = ~a_valid;
      LANE_B:  in_ready = ~b_valid;
      default: in_ready = 1'b0;
    endcase
  end

  // A transfer enables exactly the lane picked by s.
  always_comb begin
    if (in_valid && in_ready) begin
      en_a = (s == LANE_A);
      en_b = (s == LANE_B);
    end else begin
      en_a = 1'b0;
      en_b = 1'b0;
    end
  end

  nibble_lane_assembler u_lane_a (
    .clk    (clk),
    .rst    (rst),
    .en     (en_a),
    .nibble (in_nibble),
    .ready  (a_ready),
`ifdef NIBBLE_DEMUX_FLUSH_EN
    .flush  (flush),
`endif
    .word   (a_word),
    .valid  (a_valid)
  );

  nibble_lane_assembler u_lane_b (
    .clk    (clk),
    .rst    (rst),
    .en     (en_b),
    .nibble (in_nibble),
    .ready  (b_ready),
`ifdef NIBBLE_DEMUX_FLUSH_EN
    .flush  (flush),
`endif
    .word   (b_word),
    .valid  (b_valid)
  );

endmodule

// File: doc/nibble_demux_2o.md
Name: nibble_demux_2o

Overview:
- 1-input, 2-output sequential demultiplexer: steers a 4-bit nibble stream to lane A (s=0) or lane B (s=1).
- Each lane assembles NIBBLES_PER_WORD nibbles, LSB-first, into one word and holds it under a valid/ready handshake.
- Sits between the nibble-wide datapath selects and the 16-bit register/accumulator write ports.

Parameters:
- NIBBLE_W, 4, width of one input nibble.
- NIBBLES_PER_WORD, 4, nibbles per assembled word (WORD_W = NIBBLE_W*NIBBLES_PER_WORD = 16).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s  input  1  lane select: 0 = lane A, 1 = lane B; sampled with in_valid.
- in_valid  input  1  in_nibble valid this cycle.
- in_nibble  input  NIBBLE_W  input data.
- in_ready  output  1  selected lane can accept; combinational = ~a_valid when s=0, ~b_valid when s=1.
- a_word  output  WORD_W  lane A assembled word.
- a_valid  output  1  lane A word complete and held.
- a_ready  input  1  lane A consumer accepts.
- b_word  output  WORD_W  lane B assembled word.
- b_valid  output  1  lane B word complete and held.
- b_ready  input  1  lane B consumer accepts.

Behaviour:
- Reset (sync, rst=1 at an edge): per lane, count=0, word=0, valid=0. a_word=b_word=0, a_valid=b_valid=0. Reset overrides all same-cycle events. Reset mid-assembly discards partial nibbles.
- Input transfer = in_valid & in_ready. A transfer updates only the lane selected by s; the other lane's count and word are untouched.
- Per-lane state, two states:
  - FILL (valid=0): on transfer, nibble k (k=count) goes to bits [k*NIBBLE_W +: NIBBLE_W] and count increments. On the transfer with count=NIBBLES_PER_WORD-1, count wraps to 0 and the state moves to FULL. valid rises the cycle after the last nibble is accepted (latency 1).
  - FULL (valid=1): word is stable; in_ready=0 when s selects this lane. On valid&ready, go to FILL with count=0. The word register keeps its old value until overwritten nibble by nibble.
- No bypass: a lane freed by ready in cycle N accepts a new nibble from cycle N+1.
- Independence: lane A FULL does not block nibbles steered to lane B, and vice versa.
- Both lanes may be drained in the same cycle.
- in_valid=0: no state change except output handshakes. s is don't-care when in_valid=0.
- Partial words persist indefinitely while traffic goes to the other lane.

Optional Feature:
- Macro NIBBLE_DEMUX_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 at an edge sets count=0 in every lane still in FILL, discarding partial nibbles.
  - FULL lanes and their words are unaffected.
  - A transfer in the same cycle as flush is dropped; in_ready stays unchanged.
  - Priority: rst > flush > transfer.
- Undefined: port absent; behaviour as above.

Decomposition:
- Shared package nibble_demux_pkg holds:
  - NIBBLE_W, NIBBLES_PER_WORD, WORD_W.
  - LANE_A=1'b0, LANE_B=1'b1.
  - Count width = clog2(NIBBLES_PER_WORD).
  - Lane state encoding FILL=1'b0, FULL=1'b1.
- One sub-module, nibble_lane_assembler: count, word and valid for one lane, with ports en, nibble, ready, word, valid, and flush when enabled. Instantiated twice. The top holds only the steering logic and the in_ready mux.

Test Plan:
- Lane A fill: rst, then s=0, nibbles 4,3,2,1 on consecutive cycles with a_ready=0 → a_valid=1 the cycle after the 4th, a_word=16'h1234, b_valid=0 throughout.
- Backpressure: lane A FULL, s=0, in_valid=1 → in_ready=0 and a_word is held. Set a_ready=1 for one cycle → a_valid=0 next cycle, in_ready=1.
- Interleave: nibbles alternate s=0/1 with A=F,E,D,C and B=0,1,2,3 → a_word=16'hCDEF, b_word=16'h3210, both valid, each 1 cycle after its own 4th nibble.
- Independence: lane A FULL, s=1 stream 8,8,8,8 → b_word=16'h8888, in_ready=1 throughout.
- Reset mid-operation: 2 nibbles into lane B, rst for 1 cycle, then 4 nibbles 1,1,1,1 → b_word=16'h1111 and no stale nibbles.
- With NIBBLE_DEMUX_FLUSH_EN: 3 nibbles to A, flush, then A,B,C,D → a_word=16'hDCBA. A FULL lane survives flush with its word unchanged.
